mem_wb_stage: RTL
=================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have a single clock domain; reset is asynchronous, active-low.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 RegWrite_in, MemToReg_in, ret_in  input  1 each  control from MEM stage.
REQ-005 MemRead_in  input  1  MEM stage issued a read (MemRead or ret) this cycle.
REQ-006 DestReg_in  input  5  destination register.
REQ-007 ALU_result_in  input  32  ALU result from MEM stage.
REQ-008 MemRead_data_in  input  32  read data from memory controller.
REQ-009 mem_rdy  input  1  memory controller read data valid this cycle.
REQ-010 flush  input  1  kill the instruction entering or waiting in this stage.
REQ-011 RegWrite_out, MemToReg_out, ret_out  output  1 each  registered controls to WB.
REQ-012 DestReg_out  output  5; ALU_result_out, MemRead_data_out, WB_data  output  32 each.
REQ-013 mem_stall  output  1  combinational; freezes all upstream stages.
REQ-014 fwd_valid  output  1; fwd_reg  output  5; fwd_data  output  32  forwarding to EX.
REQ-015 mem_timeout  output  1  sticky read-timeout error flag.

Function
REQ-016 States SHALL be IDLE and WAIT, encoded in 1 bit.
REQ-017 IDLE, MemRead_in=0: SHALL capture all *_in fields at the next edge, 1-cycle latency.
REQ-018 IDLE, MemRead_in=1, mem_rdy=1: SHALL capture fields plus MemRead_data_in at the next edge; no stall.
REQ-019 IDLE, MemRead_in=1, mem_rdy=0: SHALL assert mem_stall in the same cycle, latch control/DestReg/ALU_result into a hold buffer, enter WAIT, and present a bubble (RegWrite_out=0, ret_out=0) on the next cycle.
REQ-020 WAIT: mem_stall SHALL stay 1 while mem_rdy=0; *_in SHALL be ignored.
REQ-021 WAIT, mem_rdy=1: mem_stall SHALL be 0 that cycle; at the edge the held fields plus MemRead_data_in SHALL be output and the state SHALL return to IDLE.
REQ-022 flush=1 SHALL override everything: at the next edge outputs become a bubble, state goes to IDLE, the hold buffer is discarded, and mem_stall is 0 in the flush cycle.
REQ-023 flush and mem_rdy in the same cycle SHALL resolve as flush (data dropped).
REQ-024 RegWrite_out SHALL be forced 0 whenever the captured DestReg equals 5'd0.
REQ-025 WB_data SHALL be MemRead_data_out when MemToReg_out=1, else ALU_result_out (combinational from registers).
REQ-026 fwd_valid SHALL equal RegWrite_out; fwd_reg = DestReg_out; fwd_data = WB_data.
REQ-027 An 8-bit wait counter SHALL clear on entering WAIT and increment each WAIT cycle, saturating at 255.
REQ-028 The counter reaching 255 SHALL set mem_timeout; it clears only on reset. The FSM keeps waiting.
REQ-029 Back-to-back reads SHALL each follow REQ-018/019 independently; no lost or duplicated instruction.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, counter 0, mem_timeout 0, and all outputs 0 (mem_stall 0, fwd_valid 0).
REQ-031 Reset asserted in WAIT SHALL abandon the pending read; the first edge after release behaves as IDLE.

Verification
REQ-032 ALU op: RegWrite_in=1, MemToReg_in=0, DestReg=5, ALU=0x0000_1234 -> next cycle RegWrite_out=1, WB_data=0x1234, fwd_reg=5, mem_stall never 1.
REQ-033 Load with mem_rdy low 3 cycles: MemToReg=1, DestReg=7, data 0xDEAD_BEEF on the 4th cycle -> mem_stall=1 for exactly 3 cycles, then WB_data=0xDEADBEEF, RegWrite_out=1, counter=3.
REQ-034 Write to r0: RegWrite_in=1, DestReg=0 -> RegWrite_out=0, fwd_valid=0.
REQ-035 Flush in WAIT coincident with mem_rdy=1 -> next cycle bubble, state IDLE, data not written, mem_stall 0 in that cycle.
REQ-036 mem_rdy held 0 for 300 cycles -> mem_timeout=1 after cycle 255, mem_stall stays 1; then rst_n pulse low mid-wait -> all outputs 0, mem_timeout 0.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if -- MEM -> WB stage bundle.
//   master : upstream/MEM side (drives *_in, mem_rdy, flush; observes WB,
//            forwarding, stall and timeout outputs)
//   slave  : the mem_wb_stage itself
// Signal names follow the pipeline's existing naming so the stage drops in
// unchanged.
interface mem_wb_stage_if;
  // MEM -> stage
  logic        RegWrite_in;
  logic        MemToReg_in;
  logic        ret_in;
  logic        MemRead_in;
  logic [4:0]  DestReg_in;
  logic [31:0] ALU_result_in;
  logic [31:0] MemRead_data_in;
  logic        mem_rdy;
  logic        flush;
  // stage -> WB / EX / hazard unit
  logic        RegWrite_out;
  logic        MemToReg_out;
  logic        ret_out;
  logic [4:0]  DestReg_out;
  logic [31:0] ALU_result_out;
  logic [31:0] MemRead_data_out;
  logic [31:0] WB_data;
  logic        mem_stall;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic        mem_timeout;

  modport master (
    output RegWrite_in, MemToReg_in, ret_in, MemRead_in, DestReg_in,
           ALU_result_in, MemRead_data_in, mem_rdy, flush,
    input  RegWrite_out, MemToReg_out, ret_out, DestReg_out, ALU_result_out,
           MemRead_data_out, WB_data, mem_stall, fwd_valid, fwd_reg,
           fwd_data, mem_timeout
  );

  modport slave (
    input  RegWrite_in, MemToReg_in, ret_in, MemRead_in, DestReg_in,
           ALU_result_in, MemRead_data_in, mem_rdy, flush,
    output RegWrite_out, MemToReg_out, ret_out, DestReg_out, ALU_result_out,
           MemRead_data_out, WB_data, mem_stall, fwd_valid, fwd_reg,
           fwd_data, mem_timeout
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage -- MEM/WB pipeline register with read-wait handling.
// Registers MEM-stage results for write-back. A read whose data is not ready
// (mem_rdy=0) parks its control fields in a hold buffer, stalls the upstream
// pipe and emits bubbles until the data arrives. An 8-bit saturating wait
// counter flags a sticky timeout after 255 wait cycles.
// Ports:
//   clk    : pipeline clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_wb_stage_if.slave (MEM inputs, WB/forward outputs,
//            mem_stall, mem_timeout)
module mem_wb_stage (
  input  logic           clk,
  input  logic           rst_n,
  mem_wb_stage_if.slave  bus
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic        ret;
    logic [4:0]  rd;
    logic [31:0] alu;
  } ctl_t;

  state_t      r_state;
  ctl_t        r_hold;
  ctl_t        r_out;
  logic [31:0] r_mdata;
  logic [7:0]  r_wcnt;
  logic        r_timeout;

  ctl_t        w_in;
  logic        w_stall;

  // Writes to r0 are architecturally dropped, so never let them reach WB.
  function automatic ctl_t wb_mask(input ctl_t c);
    ctl_t m;
    m = c;
    if (c.rd == 5'd0) m.rw = 1'b0;
    return m;
  endfunction

  assign w_in = {bus.RegWrite_in, bus.MemToReg_in, bus.ret_in,
                 bus.DestReg_in, bus.ALU_result_in};

  // Flush always releases the pipe; reset gating keeps the stall low while
  // rst_n is held even though MEM inputs may still show a pending read.
  assign w_stall = rst_n && !bus.flush && !bus.mem_rdy &&
                   ((r_state == S_WAIT) || bus.MemRead_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_hold    <= '0;
      r_out     <= '0;
      r_mdata   <= '0;
      r_wcnt    <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      // Every cycle spent in WAIT counts, including the one the data lands.
      if (r_state == S_WAIT) begin
        if (r_wcnt != 8'hFF) r_wcnt <= r_wcnt + 8'd1;
        if (r_wcnt == 8'hFE) r_timeout <= 1'b1;
      end

      if (bus.flush) begin
        r_state <= S_IDLE;
        r_hold  <= '0;
        r_out   <= '0;
        r_mdata <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.MemRead_in && !bus.mem_rdy) begin
              r_hold  <= w_in;
              r_state <= S_WAIT;
              r_wcnt  <= 8'd0;
              r_out   <= '0;
              r_mdata <= '0;
            end else begin
              r_out   <= wb_mask(w_in);
              r_mdata <= bus.MemRead_data_in;
            end
          end
          S_WAIT: begin
            if (bus.mem_rdy) begin
              r_out   <= wb_mask(r_hold);
              r_mdata <= bus.MemRead_data_in;
              r_state <= S_IDLE;
            end else begin
              r_out   <= '0;
              r_mdata <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.RegWrite_out     = r_out.rw;
  assign bus.MemToReg_out     = r_out.m2r;
  assign bus.ret_out          = r_out.ret;
  assign bus.DestReg_out      = r_out.rd;
  assign bus.ALU_result_out   = r_out.alu;
  assign bus.MemRead_data_out = r_mdata;
  assign bus.WB_data          = r_out.m2r ? r_mdata : r_out.alu;
  assign bus.mem_stall        = w_stall;
  assign bus.fwd_valid        = r_out.rw;
  assign bus.fwd_reg          = r_out.rd;
  assign bus.fwd_data         = bus.WB_data;
  assign bus.mem_timeout      = r_timeout;

endmodule
